// File: rtl/apuf_pkg.sv
// Shared definitions for the arbiter-PUF challenge/response controller.
package apuf_pkg;

    localparam int CW_DEF     = 64;  // default challenge width
    localparam int NW_DEF     = 8;   // default repeat-count / ones-counter width
    localparam int SYNC_DEPTH = 2;   // flops on each PUF return line
    localparam int TMR_W      = 16;  // width of the shared cycle timer

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_FIRE,
        ST_RELEASE,
        ST_RECOV,
        ST_DONE
    } state_t;

endpackage

// File: rtl/apuf_cycle_timer.sv
// Loadable down-counter with a zero flag, shared by the settle, fire-timeout
// and recovery phases. Loading N makes zero assert after N cycles.
module apuf_cycle_timer
    import apuf_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         rstN,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    // Load wins over counting; the counter saturates at zero.
    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/apuf_crp_controller.sv
// Measurement-side controller for the arbiter PUF: applies a challenge, fires
// the trigger a programmed number of times, and returns the majority bit and
// the count of 1 responses.
module apuf_crp_controller
    import apuf_pkg::*;
#(
    parameter int CW      = CW_DEF,
    parameter int NW      = NW_DEF,
    parameter int SETTLE  = 8,
    parameter int TIMEOUT = 255,
    parameter int RECOVER = 4
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          cmdValid,
    output logic          cmdReady,
    input  logic [CW-1:0] cmdChal,
    input  logic [NW-1:0] cmdReps,
    output logic [CW-1:0] c,
    output logic          tigSignal,
    input  logic          respReady,
    input  logic          respBit,
    output logic          rspValid,
    input  logic          rspReady,
    output logic          rspBit,
    output logic [NW-1:0] rspOnes,
    output logic          rspTimeout
);

    state_t                state;
    logic [SYNC_DEPTH-1:0] ready_sr;
    logic [SYNC_DEPTH-1:0] bit_sr;
    logic                  ready_sync;
    logic                  bit_sync;
    logic [NW-1:0]         reps;
    logic [NW-1:0]         done;
    logic [NW:0]           ones;
    logic                  majority;
    logic                  timer_load;
    logic [TMR_W-1:0]      timer_val;
    logic                  timer_zero;

    // Bring the PUF return lines into the clk domain before any use.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ready_sr <= '0;
            bit_sr   <= '0;
        end else begin
            ready_sr <= {ready_sr[SYNC_DEPTH-2:0], respReady};
            bit_sr   <= {bit_sr[SYNC_DEPTH-2:0], respBit};
        end
    end

    assign ready_sync = ready_sr[SYNC_DEPTH-1];
    assign bit_sync   = bit_sr[SYNC_DEPTH-1];

    // Strict majority over completed evaluations; a tie resolves to 0.
    assign majority = ({ones, 1'b0} > {2'b00, done});

    // Timer reloads, issued on the same edge as the matching state change.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = '0;
        case (state)
            ST_IDLE: begin
                if (cmdValid && cmdReady) begin
                    timer_load = 1'b1;
                    timer_val  = TMR_W'(SETTLE);
                end
            end
            ST_SETTLE: begin
                if (timer_zero) begin
                    timer_load = 1'b1;
                    timer_val  = TMR_W'(TIMEOUT - 1);
                end
            end
            ST_RELEASE: begin
                if (!ready_sync) begin
                    timer_load = 1'b1;
                    timer_val  = TMR_W'(RECOVER - 1);
                end
            end
            ST_RECOV: begin
                if (timer_zero && (done != reps)) begin
                    timer_load = 1'b1;
                    timer_val  = TMR_W'(SETTLE);
                end
            end
            default: ;
        endcase
    end

    apuf_cycle_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rstN     (rstN),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    // Sequencer: command accept, trigger timing, vote counters and result.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state      <= ST_IDLE;
            cmdReady   <= 1'b1;
            c          <= '0;
            tigSignal  <= 1'b0;
            reps       <= '0;
            done       <= '0;
            ones       <= '0;
            rspValid   <= 1'b0;
            rspBit     <= 1'b0;
            rspOnes    <= '0;
            rspTimeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmdValid && cmdReady) begin
                        c        <= cmdChal;
                        reps     <= (cmdReps == '0) ? NW'(1) : cmdReps;
                        ones     <= '0;
                        done     <= '0;
                        cmdReady <= 1'b0;
                        state    <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (timer_zero) begin
                        tigSignal <= 1'b1;
                        state     <= ST_FIRE;
                    end
                end
                ST_FIRE: begin
                    // A response on the expiry cycle still counts.
                    if (ready_sync) begin
                        ones      <= ones + (NW + 1)'(bit_sync);
                        done      <= done + NW'(1);
                        tigSignal <= 1'b0;
                        state     <= ST_RELEASE;
                    end else if (timer_zero) begin
                        tigSignal  <= 1'b0;
                        rspValid   <= 1'b1;
                        rspOnes    <= ones[NW-1:0];
                        rspBit     <= majority;
                        rspTimeout <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_RELEASE: begin
                    if (!ready_sync) begin
                        state <= ST_RECOV;
                    end
                end
                ST_RECOV: begin
                    if (timer_zero) begin
                        if (done == reps) begin
                            rspValid   <= 1'b1;
                            rspOnes    <= ones[NW-1:0];
                            rspBit     <= majority;
                            rspTimeout <= 1'b0;
                            state      <= ST_DONE;
                        end else begin
                            state <= ST_SETTLE;
                        end
                    end
                end
                ST_DONE: begin
                    if (rspReady) begin
                        rspValid <= 1'b0;
                        cmdReady <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apuf_crp_controller.sv
// Directed self-checking bench for apuf_crp_controller with a behavioural PUF.
//
// Hand timing with SETTLE=8, TIMEOUT=255, RECOVER=4 and a PUF that raises
// respReady d cycles after it sees the trigger (sampled on the falling edge):
//   accept A -> trigger rise R = A+9
//   respReady at R+d+0.5 -> FSM samples at R+d+3 (trigger falls there)
//   d=10: trigger high 13 cycles; respReady drops half a cycle after the fall,
//         sync low seen 3 edges after the fall -> RECOV for 4 -> SETTLE 9
//         -> rise-to-rise 29, accept-to-rspValid 29 for a single evaluation
//   d=252: sample lands on R+255, the expiry edge -> counted, no timeout
//   d=253: too late -> timeout; trigger high exactly 255 cycles
module tb_apuf_crp_controller;

    localparam int CW      = 64;
    localparam int NW      = 8;
    localparam int SETTLE  = 8;
    localparam int TIMEOUT = 255;
    localparam int RECOVER = 4;

    logic          clk = 1'b0;
    logic          rstN;
    logic          cmdValid;
    logic          cmdReady;
    logic [CW-1:0] cmdChal;
    logic [NW-1:0] cmdReps;
    logic [CW-1:0] c;
    logic          tigSignal;
    logic          respReady;
    logic          respBit;
    logic          rspValid;
    logic          rspReady;
    logic          rspBit;
    logic [NW-1:0] rspOnes;
    logic          rspTimeout;

    int tests  = 0;
    int failed = 0;

    // PUF model controls (written by the stimulus), index owned by the model.
    bit   puf_en;
    int   puf_delay;
    logic puf_bits [0:63];
    int   puf_idx = 0;

    // Trigger monitor state.
    int   cyc = 0;
    int   trig_count = 0;
    int   rises [0:63];
    int   lens  [0:63];
    int   cur_len = 0;
    logic tig_q = 1'b0;

    int accept_cyc;
    int rsp_cyc;
    int base;
    logic [CW-1:0] held_chal;

    apuf_crp_controller #(
        .CW      (CW),
        .NW      (NW),
        .SETTLE  (SETTLE),
        .TIMEOUT (TIMEOUT),
        .RECOVER (RECOVER)
    ) dut (
        .clk        (clk),
        .rstN       (rstN),
        .cmdValid   (cmdValid),
        .cmdReady   (cmdReady),
        .cmdChal    (cmdChal),
        .cmdReps    (cmdReps),
        .c          (c),
        .tigSignal  (tigSignal),
        .respReady  (respReady),
        .respBit    (respBit),
        .rspValid   (rspValid),
        .rspReady   (rspReady),
        .rspBit     (rspBit),
        .rspOnes    (rspOnes),
        .rspTimeout (rspTimeout)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Record every trigger rise time and every completed pulse length.
    initial forever begin
        @(negedge clk);
        if (tigSignal) begin
            if (!tig_q) begin
                rises[trig_count] = cyc;
                trig_count++;
                cur_len = 0;
            end
            cur_len++;
        end else if (tig_q) begin
            lens[trig_count - 1] = cur_len;
        end
        tig_q = tigSignal;
    end

    // Behavioural arbiter PUF: answer puf_delay cycles after seeing the trigger,
    // hold the answer until the trigger is seen low.
    initial begin
        respReady = 1'b0;
        respBit   = 1'b0;
        forever begin
            @(negedge clk);
            if (tigSignal) begin
                if (puf_en) begin
                    repeat (puf_delay) @(negedge clk);
                    respBit   = puf_bits[puf_idx];
                    respReady = 1'b1;
                    puf_idx++;
                    while (tigSignal) @(negedge clk);
                    respReady = 1'b0;
                    respBit   = 1'b0;
                end else begin
                    while (tigSignal) @(negedge clk);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_bits(input int n, input logic [7:0] v);
        for (int k = 0; k < n; k++) puf_bits[puf_idx + k] = v[k];
    endtask

    task automatic start_cmd(input string tag, input logic [CW-1:0] chal, input logic [NW-1:0] reps);
        check({tag, "_cmd_ready"}, cmdReady, 1'b1);
        cmdChal  = chal;
        cmdReps  = reps;
        cmdValid = 1'b1;
        @(negedge clk);
        accept_cyc = cyc;
        cmdValid   = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input int limit);
        int n;
        n = 0;
        while (!rspValid && n < limit) begin
            @(negedge clk);
            n++;
        end
        rsp_cyc = cyc;
        check({tag, "_rsp_valid"}, rspValid, 1'b1);
    endtask

    task automatic consume(input string tag);
        rspReady = 1'b1;
        @(negedge clk);
        rspReady = 1'b0;
        check({tag, "_rsp_drop"}, rspValid, 1'b0);
        check({tag, "_ready_back"}, cmdReady, 1'b1);
    endtask

    initial begin
        rstN      = 1'b0;
        cmdValid  = 1'b0;
        cmdChal   = '0;
        cmdReps   = '0;
        rspReady  = 1'b0;
        puf_en    = 1'b1;
        puf_delay = 10;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_cmd_ready", cmdReady, 1'b1);
        check("rst_c", c, 64'h0);
        check("rst_tig", tigSignal, 1'b0);
        check("rst_rsp_valid", rspValid, 1'b0);
        check("rst_rsp_bit", rspBit, 1'b0);
        check("rst_rsp_ones", rspOnes, 8'd0);
        check("rst_rsp_timeout", rspTimeout, 1'b0);
        rstN = 1'b1;
        @(negedge clk);

        // Single evaluation returning 1
        set_bits(1, 8'b1);
        base = trig_count;
        start_cmd("t1", 64'h0123_4567_89AB_CDEF, 8'd1);
        check("t1_c", c, 64'h0123_4567_89AB_CDEF);
        check("t1_busy", cmdReady, 1'b0);
        wait_rsp("t1", 500);
        check("t1_latency", rsp_cyc - accept_cyc, 29);
        check("t1_trig_count", trig_count - base, 1);
        check("t1_first_rise", rises[base] - accept_cyc, SETTLE + 1);
        check("t1_trig_len", lens[base], 13);
        check("t1_bit", rspBit, 1'b1);
        check("t1_ones", rspOnes, 8'd1);
        check("t1_timeout", rspTimeout, 1'b0);
        consume("t1");

        // Five evaluations 1,0,1,1,0 -> 3 ones, majority 1
        set_bits(5, 8'b0000_1101);
        base = trig_count;
        start_cmd("t2", 64'hFEDC_BA98_7654_3210, 8'd5);
        wait_rsp("t2", 2000);
        check("t2_trig_count", trig_count - base, 5);
        for (int i = 1; i < 5; i++) check("t2_gap", rises[base + i] - rises[base + i - 1], 29);
        check("t2_ones", rspOnes, 8'd3);
        check("t2_bit", rspBit, 1'b1);
        check("t2_timeout", rspTimeout, 1'b0);
        consume("t2");

        // Four evaluations 1,1,0,0 -> tie resolves to 0
        set_bits(4, 8'b0000_0011);
        base = trig_count;
        start_cmd("t3", 64'h0000_0000_0000_0001, 8'd4);
        wait_rsp("t3", 2000);
        check("t3_trig_count", trig_count - base, 4);
        check("t3_ones", rspOnes, 8'd2);
        check("t3_bit", rspBit, 1'b0);
        check("t3_timeout", rspTimeout, 1'b0);
        consume("t3");

        // Repeat count 0 behaves as 1
        set_bits(1, 8'b1);
        base = trig_count;
        start_cmd("t4", 64'h8000_0000_0000_0000, 8'd0);
        wait_rsp("t4", 500);
        check("t4_trig_count", trig_count - base, 1);
        check("t4_latency", rsp_cyc - accept_cyc, 29);
        check("t4_ones", rspOnes, 8'd1);
        check("t4_bit", rspBit, 1'b1);
        consume("t4");

        // PUF never answers: abort after TIMEOUT cycles of trigger
        puf_en = 1'b0;
        base = trig_count;
        start_cmd("t5", 64'h5555_AAAA_5555_AAAA, 8'd3);
        wait_rsp("t5", 2000);
        check("t5_trig_count", trig_count - base, 1);
        check("t5_trig_len", lens[base], TIMEOUT);
        check("t5_latency", rsp_cyc - accept_cyc, SETTLE + 1 + TIMEOUT);
        check("t5_timeout", rspTimeout, 1'b1);
        check("t5_ones", rspOnes, 8'd0);
        check("t5_bit", rspBit, 1'b0);
        consume("t5");
        puf_en = 1'b1;

        // Response seen on the expiry cycle wins over the timeout
        puf_delay = TIMEOUT - 3;
        set_bits(1, 8'b1);
        base = trig_count;
        start_cmd("t6", 64'h0F0F_0F0F_0F0F_0F0F, 8'd1);
        wait_rsp("t6", 2000);
        check("t6_trig_len", lens[base], TIMEOUT);
        check("t6_timeout", rspTimeout, 1'b0);
        check("t6_ones", rspOnes, 8'd1);
        check("t6_bit", rspBit, 1'b1);
        consume("t6");

        // Response one cycle too late: timeout, nothing counted
        puf_delay = TIMEOUT - 2;
        set_bits(1, 8'b1);
        base = trig_count;
        start_cmd("t7", 64'hF0F0_F0F0_F0F0_F0F0, 8'd1);
        wait_rsp("t7", 2000);
        check("t7_trig_len", lens[base], TIMEOUT);
        check("t7_timeout", rspTimeout, 1'b1);
        check("t7_ones", rspOnes, 8'd0);
        consume("t7");
        repeat (5) @(negedge clk);
        puf_delay = 10;

        // Result held while the consumer stalls; new commands ignored
        set_bits(1, 8'b1);
        held_chal = 64'hA5A5_5A5A_C3C3_3C3C;
        start_cmd("t8", held_chal, 8'd1);
        wait_rsp("t8", 500);
        cmdChal  = 64'h1234_0000_0000_4321;
        cmdReps  = 8'd2;
        cmdValid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t8_hold_valid", rspValid, 1'b1);
            check("t8_hold_ones", rspOnes, 8'd1);
            check("t8_hold_bit", rspBit, 1'b1);
            check("t8_hold_timeout", rspTimeout, 1'b0);
            check("t8_hold_busy", cmdReady, 1'b0);
            check("t8_hold_c", c, held_chal);
        end
        cmdValid = 1'b0;
        consume("t8");

        // Reset during FIRE drops the trigger asynchronously
        puf_en = 1'b0;
        base = trig_count;
        start_cmd("t9", 64'h1111_2222_3333_4444, 8'd2);
        for (int i = 0; i < 30 && !tigSignal; i++) @(negedge clk);
        check("t9_tig_up", tigSignal, 1'b1);
        @(posedge clk);
        #2 rstN = 1'b0;
        #1;
        check("t9_tig_async", tigSignal, 1'b0);
        check("t9_cmd_ready", cmdReady, 1'b1);
        check("t9_c", c, 64'h0);
        check("t9_rsp_valid", rspValid, 1'b0);
        check("t9_rsp_bit", rspBit, 1'b0);
        check("t9_rsp_ones", rspOnes, 8'd0);
        check("t9_rsp_timeout", rspTimeout, 1'b0);
        @(negedge clk);
        rstN   = 1'b1;
        puf_en = 1'b1;
        repeat (300) @(negedge clk);
        check("t9_no_result", rspValid, 1'b0);
        check("t9_no_retrigger", trig_count - base, 1);

        // Normal run after the mid-run reset
        set_bits(1, 8'b1);
        start_cmd("t10", 64'hDEAD_BEEF_CAFE_F00D, 8'd1);
        wait_rsp("t10", 500);
        check("t10_latency", rsp_cyc - accept_cyc, 29);
        check("t10_ones", rspOnes, 8'd1);
        check("t10_bit", rspBit, 1'b1);
        consume("t10");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/apuf_crp_controller.md
# apuf_crp_controller

Drives the arbiter PUF (`apufClassic`) from the measurement side. It accepts a challenge command, drives the 64-bit challenge, and fires the trigger a programmed number of times. Each trigger completes on the PUF's `respReady`/`respBit` return, and the block reports a majority-voted response bit plus the ones count to the host logic. It sits between the UART/host command path and the PUF instance and owns all trigger timing.

## Interface
Parameters:
- `CW`, 64, challenge width
- `NW`, 8, width of repeat count and ones counter
- `SETTLE`, 8, cycles the challenge is held before each trigger
- `TIMEOUT`, 255, max cycles from trigger rise to `respReady` high
- `RECOVER`, 4, idle cycles after `respReady` falls before next trigger

Ports (one clock `clk`; reset `rstN` asynchronous, active-low):
- `clk`  in  1  system clock
- `rstN`  in  1  async active-low reset
- `cmdValid`  in  1  command present
- `cmdReady`  out  1  controller can accept a command
- `cmdChal`  in  CW  challenge to apply
- `cmdReps`  in  NW  number of evaluations; 0 treated as 1
- `c`  out  CW  challenge to PUF
- `tigSignal`  out  1  trigger to PUF
- `respReady`  in  1  PUF response valid (level)
- `respBit`  in  1  PUF arbiter output
- `rspValid`  out  1  result present
- `rspReady`  in  1  consumer accepts result
- `rspBit`  out  1  majority bit
- `rspOnes`  out  NW  count of 1 responses
- `rspTimeout`  out  1  run aborted on timeout

## Operation
- States: IDLE, SETTLE, FIRE, RELEASE, RECOV, DONE.
- IDLE: `cmdReady`=1. On `cmdValid&cmdReady`, the following registers are loaded:
  - `c`←`cmdChal`
  - reps←max(`cmdReps`,1)
  - ones←0, done←0, timeout flag←0
  - Next state is SETTLE.
- SETTLE: counts SETTLE cycles with `c` stable, then goes to FIRE.
- FIRE: `tigSignal`=1 and the timer runs.
  - On `respReady`=1, sample `respBit` into ones (ones+=respBit) and done+=1, then go to RELEASE.
  - If the timer reaches TIMEOUT first, set the timeout flag and go to DONE.
- RELEASE: `tigSignal`=0; wait for `respReady`=0, then go to RECOV.
  - RELEASE has no timeout. A stuck-high `respReady` holds the FSM here until reset.
- RECOV: counts RECOVER cycles. If done==reps, go to DONE; else go to SETTLE.
- DONE: `rspValid`=1 with the following outputs, held stable until `rspReady`:
  - `rspOnes`=ones
  - `rspBit`=(2·ones>done); ties give 0
  - `rspTimeout`=flag
  - On a timeout run, `rspOnes`/`rspBit` reflect the evaluations completed before the abort.
  - On `rspValid&rspReady`, go to IDLE.
- `cmdValid` is ignored outside IDLE. `c` changes only on command accept.
- `respReady`/`respBit` are treated as asynchronous to `clk`. Both pass through a 2-flop synchronizer before use, and `respBit` is sampled from its synchronized copy in the same cycle that synchronized `respReady` is first seen high.
- ones is computed NW+1 bits wide internally, so 2·ones cannot overflow.

## Timing
- Reset values: `cmdReady`=1 (IDLE), `c`=0, `tigSignal`=0, `rspValid`=0, `rspBit`=0, `rspOnes`=0, `rspTimeout`=0. All counters and synchronizers are 0.
- Reset mid-run drops `tigSignal` immediately (async) and returns to IDLE. No partial result is emitted.
- Command accept → first `tigSignal` rise: SETTLE+1 cycles.
- Trigger rise → sample: 2 synchronizer cycles + PUF delay. Timeout fires on cycle TIMEOUT after the rise, counted from FIRE entry.
- Sample → `tigSignal` fall: 1 cycle. Minimum gap between successive triggers: 1 + sync fall (2) + RECOVER + SETTLE + 1.
- If `respReady` is seen high in the same cycle the timer reaches TIMEOUT, the response wins. It is counted and no timeout is flagged.
- `rspValid` asserts the cycle after the final RECOV cycle, or the cycle after the timeout. All outputs are registered.

## Structure
- Shared package `apuf_pkg`:
  - state enum
  - default CW/NW
  - the 2-flop synchronizer depth constant
- One sub-module: `apuf_cycle_timer`, a loadable down-counter with zero flag. It is shared by SETTLE, FIRE timeout and RECOV.
- Counters (reps, done, ones) and the FSM live in the top module.

## Test plan
- Reps=1, challenge 0x0123_4567_89AB_CDEF, model responds 1 after 10 cycles → `c` matches the challenge; one trigger pulse; `rspBit`=1, `rspOnes`=1, `rspTimeout`=0.
- Reps=5, model returns 1,0,1,1,0 → five triggers each separated by ≥ the minimum gap; `rspOnes`=3, `rspBit`=1.
- Reps=4, model returns 1,1,0,0 → tie; `rspOnes`=2, `rspBit`=0. Reps=0 → exactly one trigger.
- Model never asserts `respReady`, reps=3 → `tigSignal` high for exactly TIMEOUT cycles, then DONE with `rspTimeout`=1, `rspOnes`=0. `respReady` high on the timeout cycle instead → counted, no timeout.
- `rspReady` held low 20 cycles in DONE → `rspValid` and outputs stable; `cmdValid` during that time is not accepted. Assert `rstN` low during FIRE → `tigSignal`=0 asynchronously, all outputs at reset values.
